// File: rtl/hid_ng_pkg.sv
// Shared definitions for the hid_ng IO-MCU HID receiver: command codes,
// protocol constants and the saturating mouse-delta adder.
package hid_ng_pkg;

    typedef enum logic [7:0] {
        CMD_STATUS = 8'h00,
        CMD_KEY    = 8'h01,
        CMD_MOUSE  = 8'h02,
        CMD_JOY    = 8'h03,
        CMD_DB9    = 8'h04,
        CMD_NONE   = 8'hFF
    } cmd_e;

    localparam logic [7:0] HID_VERSION  = 8'h02;
    localparam logic [7:0] RESP_UNKNOWN = 8'hFF;

    // Signed 8-bit add clamped to +127 / -128.
    function automatic logic signed [7:0] sat_add8(input logic signed [7:0] a,
                                                   input logic signed [7:0] b);
        logic [8:0] s;
        s = {a[7], a} + {b[7], b};
        if (s[8] != s[7]) begin
            return s[8] ? 8'sh80 : 8'sh7F;
        end
        return s[7:0];
    endfunction

endpackage

// File: rtl/hid_ng_if.sv
// MCU byte-stream link: strobed command/data bytes in, registered response byte out.
interface hid_ng_if;
    logic       data_in_strobe;
    logic       data_in_start;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (output data_in_strobe, output data_in_start, output data_in,
                    input  data_out);
    modport slave  (input  data_in_strobe, input  data_in_start, input  data_in,
                    output data_out);
endinterface

// File: rtl/hid_evt_fifo.sv
// Synchronous FIFO with occupancy count; on a full FIFO a simultaneous push
// and pop are both accepted.
module hid_evt_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

    // A pop frees the slot the same cycle, so a push is still accepted when full.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/hid_ng.sv
// IO-MCU HID receiver: decodes the MCU byte stream into keyboard matrix,
// joystick and mouse state, and queues local DB9 changes for the MCU.
module hid_ng
    import hid_ng_pkg::*;
#(
    parameter int NUM_JOY   = 2,
    parameter int NUM_DB9   = 1,
    parameter int KBD_ROWS  = 8,
    parameter int KBD_COLS  = 8,
    parameter int EVT_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    hid_ng_if.slave                bus,
    input  logic [6*NUM_DB9-1:0]   db9_port,
    output logic                   irq,
    input  logic                   iack,
    input  logic [KBD_ROWS-1:0]    matrix_col_sel,
    output logic [KBD_COLS-1:0]    matrix_row_in,
    output logic [8*NUM_JOY-1:0]   joystick,
    output logic [8*NUM_JOY-1:0]   joystick_ax,
    output logic [8*NUM_JOY-1:0]   joystick_ay,
    output logic [8*NUM_JOY-1:0]   extra_button,
    output logic [NUM_JOY-1:0]     joystick_strobe,
    output logic [1:0]             mouse_btns,
    output logic [7:0]             mouse_dx,
    output logic [7:0]             mouse_dy,
    input  logic                   mouse_ack,
    output logic                   mouse_strobe
);
    localparam int DBW = 6 * NUM_DB9;
    localparam int CW  = $clog2(EVT_DEPTH) + 1;

    cmd_e                 r_cmd;
    logic [3:0]           r_idx;
    logic [7:0]           r_dout;
    logic [7:0]           r_arg [4];
    logic [KBD_COLS-1:0]  r_matrix [KBD_ROWS];
    logic [8*NUM_JOY-1:0] r_joy_d, r_joy_ax, r_joy_ay, r_joy_ex;
    logic [NUM_JOY-1:0]   r_joy_stb;
    logic [1:0]           r_btns;
    logic signed [7:0]    r_dx, r_dy;
    logic                 r_mstb;
    logic [DBW-1:0]       r_db9_p0, r_db9_p1, r_db9_p2;
    logic                 r_ovf, r_irq, r_armed;

    logic                 w_start, w_byte;
    logic                 w_key_set, w_mouse_add, w_joy_commit, w_status_rd1, w_rearm;
    logic                 w_push, w_pop, w_drop, w_full, w_empty, w_port_last;
    logic [DBW-1:0]       w_head;
    logic [CW-1:0]        w_count;
    logic [5:0]           w_head6, w_live6;
    logic [7:0]           w_resp;
    logic [KBD_COLS-1:0]  w_row_in;

    assign w_start      = bus.data_in_strobe && bus.data_in_start;
    assign w_byte       = bus.data_in_strobe && !bus.data_in_start;
    assign w_key_set    = w_byte && (r_cmd == CMD_KEY)    && (r_idx == 4'd1);
    assign w_mouse_add  = w_byte && (r_cmd == CMD_MOUSE)  && (r_idx == 4'd2);
    assign w_joy_commit = w_byte && (r_cmd == CMD_JOY)    && (r_idx == 4'd4);
    assign w_status_rd1 = w_byte && (r_cmd == CMD_STATUS) && (r_idx == 4'd1);
    assign w_rearm      = w_start && (r_cmd == CMD_DB9);

    // Port addressed by the current CMD 4 byte; the FIFO pops after the last port.
    always_comb begin
        w_head6     = '0;
        w_live6     = '0;
        w_port_last = 1'b0;
        for (int p = 0; p < NUM_DB9; p++) begin
            if ((int'(r_idx) % NUM_DB9) == p) begin
                w_head6     = w_head[p*6 +: 6];
                w_live6     = r_db9_p1[p*6 +: 6];
                w_port_last = (p == NUM_DB9 - 1);
            end
        end
    end

    assign w_pop  = w_byte && (r_cmd == CMD_DB9) && w_port_last && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    always_comb begin
        w_resp = 8'h00;
        case (r_cmd)
            CMD_STATUS: begin
                if (r_idx == 4'd0)      w_resp = HID_VERSION;
                else if (r_idx == 4'd1) w_resp = {r_ovf, 3'b000, 4'(w_count)};
            end
            CMD_KEY, CMD_MOUSE, CMD_JOY: w_resp = 8'h00;
            CMD_DB9: w_resp = {2'b00, (w_empty ? w_live6 : w_head6)};
            default: w_resp = RESP_UNKNOWN;
        endcase
    end

    // Parser: command/index tracking and the registered response byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd  <= CMD_NONE;
            r_idx  <= '0;
            r_dout <= 8'h00;
        end else if (w_start) begin
            r_cmd  <= cmd_e'(bus.data_in);
            r_idx  <= '0;
            r_dout <= 8'h00;
        end else if (w_byte) begin
            if (r_idx != 4'hF) r_idx <= r_idx + 4'd1;
            r_dout <= w_resp;
        end
    end

    // Argument bytes are held until the completing byte of the command.
    always_ff @(posedge clk) begin
        if (w_byte && (r_idx < 4'd4)) r_arg[r_idx[1:0]] <= bus.data_in;
    end

    // Out-of-range row/column never matches a loop index, so it is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < KBD_ROWS; r++) r_matrix[r] <= '1;
        end else if (w_key_set) begin
            for (int r = 0; r < KBD_ROWS; r++) begin
                for (int c = 0; c < KBD_COLS; c++) begin
                    if ((r_arg[0][6:0] == 7'(r)) && (bus.data_in == 8'(c)))
                        r_matrix[r][c] <= ~r_arg[0][7];
                end
            end
        end
    end

    always_comb begin
        w_row_in = '1;
        for (int r = 0; r < KBD_ROWS; r++) begin
            if (!matrix_col_sel[r]) w_row_in = w_row_in & r_matrix[r];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_joy_d   <= '0;
            r_joy_ax  <= '0;
            r_joy_ay  <= '0;
            r_joy_ex  <= '0;
            r_joy_stb <= '0;
        end else begin
            r_joy_stb <= '0;
            for (int j = 0; j < NUM_JOY; j++) begin
                if (w_joy_commit && (r_arg[0] == 8'(j))) begin
                    r_joy_d[j*8 +: 8]  <= r_arg[1];
                    r_joy_ax[j*8 +: 8] <= r_arg[2];
                    r_joy_ay[j*8 +: 8] <= r_arg[3];
                    r_joy_ex[j*8 +: 8] <= bus.data_in;
                    r_joy_stb[j]       <= 1'b1;
                end
            end
        end
    end

    // An ack coinciding with an add discards the old totals but keeps the new packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btns <= '0;
            r_dx   <= '0;
            r_dy   <= '0;
            r_mstb <= 1'b0;
        end else begin
            r_mstb <= w_mouse_add;
            if (w_mouse_add) begin
                r_btns <= r_arg[0][1:0];
                if (mouse_ack) begin
                    r_dx <= signed'(r_arg[1]);
                    r_dy <= signed'(bus.data_in);
                end else begin
                    r_dx <= sat_add8(r_dx, signed'(r_arg[1]));
                    r_dy <= sat_add8(r_dy, signed'(bus.data_in));
                end
            end else if (mouse_ack) begin
                r_dx <= '0;
                r_dy <= '0;
            end
        end
    end

    // DB9 stage p0/p1: synchroniser; p2: last snapshot for change detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db9_p0 <= '0;
            r_db9_p1 <= '0;
            r_db9_p2 <= '0;
        end else begin
            r_db9_p0 <= db9_port;
            r_db9_p1 <= r_db9_p0;
            r_db9_p2 <= r_db9_p1;
        end
    end

    assign w_push = (r_db9_p1 != r_db9_p2);

    hid_evt_fifo #(
        .WIDTH (DBW),
        .DEPTH (EVT_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_data  (r_db9_p1),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A pending backlog at re-arm raises irq just like a fresh push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf   <= 1'b0;
            r_irq   <= 1'b0;
            r_armed <= 1'b1;
        end else begin
            if (w_drop)            r_ovf <= 1'b1;
            else if (w_status_rd1) r_ovf <= 1'b0;

            if (r_armed && (w_push || !w_empty)) begin
                r_irq   <= 1'b1;
                r_armed <= 1'b0;
            end else begin
                if (iack)    r_irq   <= 1'b0;
                if (w_rearm) r_armed <= 1'b1;
            end
        end
    end

    assign bus.data_out    = r_dout;
    assign irq             = r_irq;
    assign matrix_row_in   = w_row_in;
    assign joystick        = r_joy_d;
    assign joystick_ax     = r_joy_ax;
    assign joystick_ay     = r_joy_ay;
    assign extra_button    = r_joy_ex;
    assign joystick_strobe = r_joy_stb;
    assign mouse_btns      = r_btns;
    assign mouse_dx        = r_dx;
    assign mouse_dy        = r_dy;
    assign mouse_strobe    = r_mstb;

endmodule

// File: tb/tb_hid_ng.sv
// Directed bench for hid_ng: keyboard, mouse, joystick, DB9 FIFO/irq and reset.
module tb_hid_ng;

    localparam int NUM_JOY   = 2;
    localparam int NUM_DB9   = 2;
    localparam int KBD_ROWS  = 8;
    localparam int KBD_COLS  = 8;
    localparam int EVT_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] db9_port;
    logic        iack;
    logic [7:0]  matrix_col_sel;
    logic [7:0]  matrix_row_in;
    logic [15:0] joystick, joystick_ax, joystick_ay, extra_button;
    logic [1:0]  joystick_strobe;
    logic [1:0]  mouse_btns;
    logic [7:0]  mouse_dx, mouse_dy;
    logic        mouse_ack;
    logic        mouse_strobe;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hid_ng_if bus ();

    hid_ng #(
        .NUM_JOY   (NUM_JOY),
        .NUM_DB9   (NUM_DB9),
        .KBD_ROWS  (KBD_ROWS),
        .KBD_COLS  (KBD_COLS),
        .EVT_DEPTH (EVT_DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus),
        .db9_port        (db9_port),
        .irq             (irq),
        .iack            (iack),
        .matrix_col_sel  (matrix_col_sel),
        .matrix_row_in   (matrix_row_in),
        .joystick        (joystick),
        .joystick_ax     (joystick_ax),
        .joystick_ay     (joystick_ay),
        .extra_button    (extra_button),
        .joystick_strobe (joystick_strobe),
        .mouse_btns      (mouse_btns),
        .mouse_dx        (mouse_dx),
        .mouse_dy        (mouse_dy),
        .mouse_ack       (mouse_ack),
        .mouse_strobe    (mouse_strobe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Called at a falling edge; the byte is taken on the next rising edge.
    task automatic send(input logic st, input logic [7:0] d);
        bus.data_in_strobe = 1'b1;
        bus.data_in_start  = st;
        bus.data_in        = d;
        @(negedge clk);
        bus.data_in_strobe = 1'b0;
        bus.data_in_start  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] v [5];
        v[0] = {6'h11, 6'h01};
        v[1] = {6'h12, 6'h02};
        v[2] = {6'h13, 6'h03};
        v[3] = {6'h14, 6'h04};
        v[4] = {6'h15, 6'h05};

        bus.data_in_strobe = 1'b0;
        bus.data_in_start  = 1'b0;
        bus.data_in        = 8'h00;
        db9_port           = 12'h000;
        iack               = 1'b0;
        mouse_ack          = 1'b0;
        matrix_col_sel     = 8'h00;

        // Reset values
        idle(3);
        chk("rst_data_out", bus.data_out, 8'h00);
        chk("rst_irq", irq, 1'b0);
        chk("rst_matrix", matrix_row_in, 8'hFF);
        chk("rst_joystick", joystick, 16'h0000);
        chk("rst_mouse_dx", mouse_dx, 8'h00);
        chk("rst_mouse_strobe", mouse_strobe, 1'b0);
        reset_n = 1'b1;
        idle(1);

        // Keyboard matrix
        matrix_col_sel = 8'hF7;
        send(1, 8'h01); send(0, 8'h83); send(0, 8'h05);
        chk("key_press", matrix_row_in, 8'hDF);
        matrix_col_sel = 8'hFF;
        idle(1);
        chk("key_unselected", matrix_row_in, 8'hFF);
        matrix_col_sel = 8'hF7;
        send(1, 8'h01); send(0, 8'h03); send(0, 8'h05);
        chk("key_release", matrix_row_in, 8'hFF);
        matrix_col_sel = 8'h00;
        send(1, 8'h01); send(0, 8'h94); send(0, 8'h05);
        chk("key_row_oob", matrix_row_in, 8'hFF);
        send(1, 8'h01); send(0, 8'h83); send(0, 8'h09);
        chk("key_col_oob", matrix_row_in, 8'hFF);

        // Mouse accumulation and saturation
        send(1, 8'h02); send(0, 8'h01); send(0, 8'd100); send(0, 8'h00);
        chk("mouse_strobe_hi", mouse_strobe, 1'b1);
        chk("mouse_dx_100", mouse_dx, 8'd100);
        chk("mouse_btns", mouse_btns, 2'b01);
        idle(1);
        chk("mouse_strobe_lo", mouse_strobe, 1'b0);
        send(1, 8'h02); send(0, 8'h02); send(0, 8'd100); send(0, 8'hF6);
        chk("mouse_dx_sat_pos", mouse_dx, 8'h7F);
        chk("mouse_dy_neg", mouse_dy, 8'hF6);
        send(1, 8'h02); send(0, 8'h00); send(0, 8'h80); send(0, 8'h80);
        chk("mouse_dx_m1", mouse_dx, 8'hFF);
        send(1, 8'h02); send(0, 8'h00); send(0, 8'h80); send(0, 8'h80);
        chk("mouse_dx_sat_neg", mouse_dx, 8'h80);
        chk("mouse_dy_sat_neg", mouse_dy, 8'h80);
        mouse_ack = 1'b1;
        idle(1);
        mouse_ack = 1'b0;
        chk("mouse_ack_dx", mouse_dx, 8'h00);
        chk("mouse_ack_dy", mouse_dy, 8'h00);
        send(1, 8'h02); send(0, 8'h00); send(0, 8'h0A); send(0, 8'h0A);
        send(1, 8'h02); send(0, 8'h00); send(0, 8'h05);
        mouse_ack = 1'b1;
        send(0, 8'hFD);
        mouse_ack = 1'b0;
        chk("mouse_ack_add_dx", mouse_dx, 8'h05);
        chk("mouse_ack_add_dy", mouse_dy, 8'hFD);

        // Joystick
        send(1, 8'h03); send(0, 8'h01); send(0, 8'h11); send(0, 8'h80);
        send(0, 8'h40); send(0, 8'h03);
        chk("joy_digital", joystick, 16'h1100);
        chk("joy_ax", joystick_ax, 16'h8000);
        chk("joy_ay", joystick_ay, 16'h4000);
        chk("joy_extra", extra_button, 16'h0300);
        chk("joy_strobe", joystick_strobe, 2'b10);
        idle(1);
        chk("joy_strobe_lo", joystick_strobe, 2'b00);
        send(1, 8'h03); send(0, 8'h05); send(0, 8'h22); send(0, 8'h22);
        send(0, 8'h22); send(0, 8'h22);
        chk("joy_bad_dev", joystick, 16'h1100);
        chk("joy_bad_strobe", joystick_strobe, 2'b00);

        // Unknown command
        send(1, 8'h07); send(0, 8'h00);
        chk("unknown_cmd", bus.data_out, 8'hFF);

        // DB9 overflow: five changes into a four-deep FIFO
        for (int k = 0; k < 5; k++) begin
            db9_port = v[k];
            idle(6);
        end
        chk("db9_irq", irq, 1'b1);
        send(1, 8'h00); send(0, 8'h00);
        chk("status_version", bus.data_out, 8'h02);
        send(0, 8'h00);
        chk("status_ovf", bus.data_out, 8'h84);
        send(1, 8'h00); send(0, 8'h00); send(0, 8'h00);
        chk("status_ovf_clr", bus.data_out, 8'h04);
        iack = 1'b1;
        idle(1);
        iack = 1'b0;
        chk("iack_clear", irq, 1'b0);

        // DB9 reads, oldest first, one pop per port pair
        send(1, 8'h04);
        send(0, 8'h00); chk("db9_rd0_p0", bus.data_out, 8'h01);
        send(0, 8'h00); chk("db9_rd0_p1", bus.data_out, 8'h11);
        send(0, 8'h00); chk("db9_rd1_p0", bus.data_out, 8'h02);
        send(0, 8'h00); chk("db9_rd1_p1", bus.data_out, 8'h12);
        send(1, 8'h00); send(0, 8'h00);
        chk("rearm_irq", irq, 1'b1);
        send(0, 8'h00);
        chk("status_count2", bus.data_out, 8'h02);
        iack = 1'b1;
        idle(1);
        iack = 1'b0;
        send(1, 8'h04);
        send(0, 8'h00); chk("db9_rd2_p0", bus.data_out, 8'h03);
        send(0, 8'h00); chk("db9_rd2_p1", bus.data_out, 8'h13);
        send(0, 8'h00); chk("db9_rd3_p0", bus.data_out, 8'h04);
        send(0, 8'h00); chk("db9_rd3_p1", bus.data_out, 8'h14);
        send(0, 8'h00); chk("db9_live_p0", bus.data_out, 8'h05);
        send(0, 8'h00); chk("db9_live_p1", bus.data_out, 8'h15);
        send(1, 8'h00); send(0, 8'h00); send(0, 8'h00);
        chk("status_empty", bus.data_out, 8'h00);
        idle(1);
        chk("rearm_empty_irq", irq, 1'b0);

        // Reset in the middle of a key command
        matrix_col_sel = 8'hF7;
        send(1, 8'h01); send(0, 8'h83); send(0, 8'h05);
        chk("key_pre_reset", matrix_row_in, 8'hDF);
        send(1, 8'h01); send(0, 8'h84);
        reset_n = 1'b0;
        idle(1);
        chk("reset_matrix", matrix_row_in, 8'hFF);
        chk("reset_data_out", bus.data_out, 8'h00);
        reset_n = 1'b1;
        idle(1);
        send(1, 8'h01); send(0, 8'h83); send(0, 8'h02);
        chk("key_after_reset", matrix_row_in, 8'hFB);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
